spi_slave: RTL and testbench

- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first), the device-side counterpart to the team's spi_master.
- Oversamples the external sck/ss_n/mosi pins in the system clk domain.
- Deserialises mosi into parallel bytes and serialises a host-loaded byte onto miso.
- Used for board-level loopback against spi_master and for emulating sensor chips in system test.

---
 rtl/spi_slave.sv | 153 +++++++++++++++
 tb/tb_spi_slave.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 responder, oversampled in the clk domain. It receives MSB-first words
// on mosi and returns a host-loaded word, or IDLE_WORD when nothing is loaded, on miso.
module spi_slave #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  new_data,
  output logic                  busy,
  output logic                  underrun
);

  localparam int             CW   = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sck_q;
  logic [1:0]              ss_q, mosi_q;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    tx_full_q, tx_full_d;
  logic                    new_data_q, new_data_d;
  logic                    underrun_q, underrun_d;
  logic                    consume;
  logic                    sck_rise, sck_fall, ss_sync;

  // Pad synchronisers; sck gets a third flop so edges are seen one flop past the sync pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q  <= 3'b000;
      ss_q   <= 2'b11;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ss_q   <= {ss_q[0], ss_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_sync  = ss_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      tx_buf_q   <= '0;
      data_out_q <= '0;
      tx_full_q  <= 1'b0;
      new_data_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      tx_buf_q   <= tx_buf_d;
      data_out_q <= data_out_d;
      tx_full_q  <= tx_full_d;
      new_data_q <= new_data_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    tx_buf_d   = tx_buf_q;
    data_out_d = data_out_q;
    tx_full_d  = tx_full_q;
    new_data_d = 1'b0;
    underrun_d = 1'b0;
    consume    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ss_sync) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          consume   = 1'b1;
        end
      end
      default: begin
        // Deselect takes priority over any sck edge seen in the same clk.
        if (ss_sync) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          tx_shift_d = '0;
          rx_shift_d = '0;
        end else begin
          if (sck_rise) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_q[1]};
            if (bit_cnt_q == LAST) begin
              data_out_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_q[1]};
              new_data_d = 1'b1;
              bit_cnt_d  = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (sck_fall) begin
            if (bit_cnt_q == '0) consume = 1'b1;
            else                 tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
    endcase

    // Consumption looks at the buffer before this clk's load is applied.
    if (consume) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = IDLE_WORD;
        underrun_d = 1'b1;
      end
    end
    if (load && !tx_full_q) begin
      tx_buf_d  = data_in;
      tx_full_d = 1'b1;
    end
  end

  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy;
  assign miso     = busy & tx_shift_q[DATA_WIDTH-1];
  assign tx_ready = ~tx_full_q;
  assign data_out = data_out_q;
  assign new_data = new_data_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model with a 16-clk sck period, plus
// pulse monitors for new_data and underrun.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, new_data, busy, underrun;
  logic       load = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  int         vectors = 0;
  int         miscompares = 0;
  int         nd_cnt = 0;
  int         ur_cnt = 0;
  int         ur_at_last = 0;
  logic [7:0] rx_log [0:15];
  logic [15:0] got_w;
  int         n0, u0;

  spi_slave #(.DATA_WIDTH(8), .IDLE_WORD(8'hFF)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .data_in(data_in), .load(load),
    .tx_ready(tx_ready), .data_out(data_out), .new_data(new_data),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (new_data === 1'b1) begin
      if (nd_cnt < 16) rx_log[nd_cnt] = data_out;
      nd_cnt++;
    end
    if (underrun === 1'b1) ur_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [7:0] d);
    data_in = d;
    load    = 1'b1;
    wait_clk(1);
    load    = 1'b0;
  endtask

  // Mode-0 master: mosi changes while sck is low, miso is sampled just before each rise.
  task automatic xfer(input logic [15:0] mw, input int nbits, output logic [15:0] sw);
    sw   = '0;
    ss_n = 1'b0;
    wait_clk(8);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = mw[i];
      wait_clk(8);
      sw  = {sw[14:0], miso};
      sck = 1'b1;
      if (i == 0) ur_at_last = ur_cnt;
      wait_clk(8);
      sck = 1'b0;
    end
    wait_clk(8);
    ss_n = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    wait_clk(3);
    rst = 1'b1;
    wait_clk(2);
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_dout", data_out, 0);
    chk("rst_newdata", new_data, 0);
    chk("rst_underrun", underrun, 0);

    // Single byte
    ld(8'hA5);
    chk("single_ready_loaded", tx_ready, 0);
    n0 = nd_cnt;
    fork
      xfer(16'h0033, 8, got_w);
      begin
        wait_clk(6);
        chk("single_busy", busy, 1);
        chk("single_oe", miso_oe, 1);
        chk("single_ready_after_ss", tx_ready, 1);
      end
    join
    chk("single_miso", got_w[7:0], 8'hA5);
    chk("single_dout", data_out, 8'h33);
    chk("single_nd_pulses", nd_cnt - n0, 1);
    chk("single_busy_after", busy, 0);

    // Back-to-back words under one select
    ld(8'h3C);
    n0 = nd_cnt;
    fork
      xfer(16'h0FF0, 16, got_w);
      begin
        for (int k = 0; k < 400 && tx_ready !== 1'b1; k++) wait_clk(1);
        chk("b2b_ready_seen", tx_ready, 1);
        ld(8'hC3);
      end
    join
    chk("b2b_miso", got_w, 16'h3CC3);
    chk("b2b_nd_pulses", nd_cnt - n0, 2);
    chk("b2b_word0", rx_log[n0], 8'h0F);
    chk("b2b_word1", rx_log[n0+1], 8'hF0);

    // Underrun: nothing loaded
    u0 = ur_cnt;
    xfer(16'h005A, 8, got_w);
    chk("ur_miso", got_w[7:0], 8'hFF);
    chk("ur_pulses_in_word", ur_at_last - u0, 1);
    chk("ur_dout", data_out, 8'h5A);

    // Abort after 5 rises, then a clean frame
    n0 = nd_cnt;
    xfer(16'h001B, 5, got_w);
    chk("abort_nd", nd_cnt - n0, 0);
    chk("abort_dout", data_out, 8'h5A);
    xfer(16'h0081, 8, got_w);
    chk("after_abort_dout", data_out, 8'h81);
    chk("after_abort_nd", nd_cnt - n0, 1);

    // Load collision: second load while full is dropped
    ld(8'h55);
    ld(8'h77);
    chk("coll_ready", tx_ready, 0);
    xfer(16'h0000, 8, got_w);
    chk("coll_miso", got_w[7:0], 8'h55);
    chk("coll_ready_after", tx_ready, 1);
    xfer(16'h0000, 8, got_w);
    chk("coll_no_second", got_w[7:0], 8'hFF);

    // Asynchronous reset mid-frame
    ld(8'h99);
    n0 = nd_cnt;
    fork
      xfer(16'h00FF, 8, got_w);
      begin
        wait_clk(44);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_oe", miso_oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", tx_ready, 1);
        chk("mid_rst_dout", data_out, 0);
        wait_clk(3);
        rst = 1'b1;
      end
    join
    chk("mid_rst_no_nd", nd_cnt - n0, 0);
    chk("mid_rst_dout_after", data_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
